// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath/memory.
// The master side is the controller: it reads instruction fields, the ALU zero
// flag and the memory ready, and drives every select, enable and strobe.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] zeroext;
    logic [2:0] alucontrol;
    logic       fault;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
               regwrite, alusrca, alusrcb, pcsrc, zeroext, alucontrol,
               fault, state_dbg
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
               regwrite, alusrca, alusrcb, pcsrc, zeroext, alucontrol,
               fault, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM for a shared-memory datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on mem_ready in the
// memory states with an optional timeout, and parks in a sticky FAULT state on
// illegal instructions or a memory timeout (leaving FAULT needs reset).
// Optional feature macro: MC_IMM_LOGIC_EN adds andi/ori (ANDIEX/ORIEX states);
// without it andi/ori decode to FAULT and zeroext is constant 00.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_ctrl_if.master     bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_IMM_LOGIC_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_IMMWB  = 4'd10,
        S_JMP    = 4'd11,
`ifdef MC_IMM_LOGIC_EN
        S_ANDIEX = 4'd12,
        S_ORIEX  = 4'd13,
`endif
        S_FAULT  = 4'd15
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    // Raw (ungated) control outputs for the current state
    logic       mem_req_c, iord_c, memwrite_c, irwrite_c, pcen_c;
    logic       regdst_c, memtoreg_c, regwrite_c, alusrca_c, fault_c;
    logic [1:0] alusrcb_c, pcsrc_c, zeroext_c;
    logic [2:0] alucontrol_c;

    // Only the five supported R-type functions are legal
    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type function
    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    assign cnt_inc     = cnt_q + CNT_W'(1);
    // The limit is reached on the cycle whose wait would bring the count to MEM_TIMEOUT
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TIMEOUT_C);

    // State and wait-counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait counter and per-state control outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        mem_req_c    = 1'b0;
        iord_c       = 1'b0;
        memwrite_c   = 1'b0;
        irwrite_c    = 1'b0;
        pcen_c       = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        regwrite_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        zeroext_c    = 2'b00;
        alucontrol_c = 3'b010;
        fault_c      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb_c = 2'b01;
                irwrite_c = bus.mem_ready;
                pcen_c    = bus.mem_ready;
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timeout_hit) state_d = S_FAULT;
                else                cnt_d   = cnt_inc;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_legal(bus.funct) ? S_RTEX : S_FAULT;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JMP;
`ifdef MC_IMM_LOGIC_EN
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_ORI:       state_d = S_ORIEX;
`endif
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready)  state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_FAULT;
                else                cnt_d   = cnt_inc;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c  = 1'b1;
                iord_c     = 1'b1;
                memwrite_c = bus.mem_ready;
                if (bus.mem_ready)  state_d = S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
                else                cnt_d   = cnt_inc;
            end
            S_RTEX: begin
                alusrca_c    = 1'b1;
                alucontrol_c = rtype_alu(bus.funct);
                state_d      = S_RTWB;
            end
            S_RTWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alusrca_c    = 1'b1;
                alucontrol_c = 3'b110;
                pcsrc_c      = 2'b01;
                pcen_c       = bus.zero;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JMP: begin
                pcsrc_c = 2'b10;
                pcen_c  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_IMM_LOGIC_EN
            S_ANDIEX: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                zeroext_c    = 2'b01;
                alucontrol_c = 3'b000;
                state_d      = S_IMMWB;
            end
            S_ORIEX: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                zeroext_c    = 2'b01;
                alucontrol_c = 3'b001;
                state_d      = S_IMMWB;
            end
`endif
            S_FAULT: begin
                fault_c = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Force every output low while reset is held so an abandoned write cannot strobe
    always_comb begin
        bus.mem_req    = reset & mem_req_c;
        bus.iord       = reset & iord_c;
        bus.memwrite   = reset & memwrite_c;
        bus.irwrite    = reset & irwrite_c;
        bus.pcen       = reset & pcen_c;
        bus.regdst     = reset & regdst_c;
        bus.memtoreg   = reset & memtoreg_c;
        bus.regwrite   = reset & regwrite_c;
        bus.alusrca    = reset & alusrca_c;
        bus.alusrcb    = reset ? alusrcb_c    : 2'b00;
        bus.pcsrc      = reset ? pcsrc_c      : 2'b00;
        bus.zeroext    = reset ? zeroext_c    : 2'b00;
        bus.alucontrol = reset ? alucontrol_c : 3'b000;
        bus.fault      = reset & fault_c;
        bus.state_dbg  = reset ? state_q      : 4'd0;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: instruction sequences, memory
// wait handshake, timeout fault (with and without a timeout), illegal decode,
// optional andi/ori and asynchronous reset in the middle of a store.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();
    mips_multicycle_ctrl_if bus_nt();

    assign bus_nt.op        = bus.op;
    assign bus_nt.funct     = bus.funct;
    assign bus_nt.zero      = bus.zero;
    assign bus_nt.mem_ready = bus.mem_ready;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    mips_multicycle_ctrl #(.MEM_TIMEOUT(0), .CNT_W(5)) dut_nt (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nt.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL rst_state act=%0d exp=0", bus.state_dbg); end
        checks++;
        if ({bus.mem_req, bus.irwrite, bus.pcen, bus.fault, bus.alusrcb, bus.alucontrol} !== 9'd0) begin
            errors++; $display("FAIL rst_outputs act=%b exp=0", {bus.mem_req, bus.irwrite, bus.pcen, bus.fault, bus.alusrcb, bus.alucontrol});
        end
        tick();
        checks++;
        if (bus.state_dbg !== 4'd0 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_held act_state=%0d act_req=%b exp=0/0", bus.state_dbg, bus.mem_req);
        end
    endtask

    task automatic test_lw();
        logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();
        bus.op = 6'b100011; bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.state_dbg !== es[i]) begin errors++; $display("FAIL lw_state[%0d] act=%0d exp=%0d", i, bus.state_dbg, es[i]); end
            checks++;
            if (bus.regwrite !== (i == 4) || bus.memtoreg !== (i == 4) || bus.memwrite !== 1'b0) begin
                errors++; $display("FAIL lw_wb[%0d] act_rw=%b act_m2r=%b act_mw=%b exp=%b/%b/0", i, bus.regwrite, bus.memtoreg, bus.memwrite, i == 4, i == 4);
            end
            if (i == 0) begin
                checks++;
                if ({bus.mem_req, bus.iord, bus.irwrite, bus.pcen, bus.alusrcb} !== 6'b101101) begin
                    errors++; $display("FAIL lw_fetch act=%b exp=101101", {bus.mem_req, bus.iord, bus.irwrite, bus.pcen, bus.alusrcb});
                end
            end
            if (i == 1) begin
                checks++;
                if (bus.alusrcb !== 2'b11 || bus.alucontrol !== 3'b010) begin
                    errors++; $display("FAIL lw_decode act_b=%b act_alu=%b exp=11/010", bus.alusrcb, bus.alucontrol);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.iord !== 1'b1) begin
                    errors++; $display("FAIL lw_memrd act_req=%b act_iord=%b exp=1/1", bus.mem_req, bus.iord);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL lw_return act=%0d exp=0", bus.state_dbg); end
    endtask

    task automatic test_sw_wait();
        int held;
        do_reset();
        bus.op = 6'b101011; bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        held = 0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.state_dbg == 4'd5) held++;
            checks++;
            if (bus.memwrite !== 1'b0 || bus.mem_req !== 1'b1) begin
                errors++; $display("FAIL sw_wait[%0d] act_mw=%b act_req=%b exp=0/1", i, bus.memwrite, bus.mem_req);
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        if (bus.state_dbg == 4'd5) held++;
        checks++;
        if (bus.memwrite !== 1'b1) begin errors++; $display("FAIL sw_strobe act=%b exp=1", bus.memwrite); end
        checks++;
        if (held !== 4) begin errors++; $display("FAIL sw_hold act=%0d exp=4", held); end
        tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0 || bus.memwrite !== 1'b0) begin
            errors++; $display("FAIL sw_return act_state=%0d act_mw=%b exp=0/0", bus.state_dbg, bus.memwrite);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alu [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            bus.op = 6'b000000; bus.funct = fn[k]; bus.mem_ready = 1'b1;
            tick(); tick();
            #1;
            checks++;
            if (bus.state_dbg !== 4'd6 || bus.alucontrol !== alu[k] || bus.alusrca !== 1'b1 || bus.alusrcb !== 2'b00) begin
                errors++; $display("FAIL rt_ex[%0d] act_state=%0d act_alu=%b act_a=%b act_b=%b exp=6/%b/1/00", k, bus.state_dbg, bus.alucontrol, bus.alusrca, bus.alusrcb, alu[k]);
            end
            tick();
            #1;
            checks++;
            if (bus.state_dbg !== 4'd7 || bus.regwrite !== 1'b1 || bus.regdst !== 1'b1) begin
                errors++; $display("FAIL rt_wb[%0d] act_state=%0d act_rw=%b act_rd=%b exp=7/1/1", k, bus.state_dbg, bus.regwrite, bus.regdst);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            bus.op = 6'b000100; bus.zero = z[0]; bus.mem_ready = 1'b1;
            tick(); tick();
            #1;
            checks++;
            if (bus.state_dbg !== 4'd8 || bus.pcen !== z[0] || bus.pcsrc !== 2'b01 || bus.alucontrol !== 3'b110) begin
                errors++; $display("FAIL beq_z%0d act_state=%0d act_pcen=%b act_pcsrc=%b act_alu=%b exp=8/%0d/01/110", z, bus.state_dbg, bus.pcen, bus.pcsrc, bus.alucontrol, z);
            end
            tick();
            #1;
            checks++;
            if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL beq_return_z%0d act=%0d exp=0", z, bus.state_dbg); end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_addi_jmp();
        do_reset();
        bus.op = 6'b001000; bus.mem_ready = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd9 || bus.alusrcb !== 2'b10 || bus.zeroext !== 2'b00 || bus.alusrca !== 1'b1) begin
            errors++; $display("FAIL addi_ex act_state=%0d act_b=%b act_zx=%b exp=9/10/00", bus.state_dbg, bus.alusrcb, bus.zeroext);
        end
        tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd10 || bus.regwrite !== 1'b1 || bus.regdst !== 1'b0) begin
            errors++; $display("FAIL addi_wb act_state=%0d act_rw=%b act_rd=%b exp=10/1/0", bus.state_dbg, bus.regwrite, bus.regdst);
        end
        do_reset();
        bus.op = 6'b000010;
        tick(); tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd11 || bus.pcsrc !== 2'b10 || bus.pcen !== 1'b1) begin
            errors++; $display("FAIL jmp act_state=%0d act_pcsrc=%b act_pcen=%b exp=11/10/1", bus.state_dbg, bus.pcsrc, bus.pcen);
        end
        tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL jmp_return act=%0d exp=0", bus.state_dbg); end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'b000000, 6'b111111};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.op = ops[k]; bus.funct = 6'b000000; bus.mem_ready = 1'b1;
            tick(); tick(); tick(); tick();
            #1;
            checks++;
            if (bus.state_dbg !== 4'd15 || bus.fault !== 1'b1 || bus.mem_req !== 1'b0 || bus.pcen !== 1'b0) begin
                errors++; $display("FAIL illegal[%0d] act_state=%0d act_fault=%b act_req=%b exp=15/1/0", k, bus.state_dbg, bus.fault, bus.mem_req);
            end
        end
    endtask

    task automatic test_ori();
        do_reset();
        bus.op = 6'b001101; bus.mem_ready = 1'b1;
        tick(); tick();
        #1;
`ifdef MC_IMM_LOGIC_EN
        checks++;
        if (bus.state_dbg !== 4'd13 || bus.alucontrol !== 3'b001 || bus.zeroext !== 2'b01 || bus.alusrcb !== 2'b10) begin
            errors++; $display("FAIL ori_ex act_state=%0d act_alu=%b act_zx=%b exp=13/001/01", bus.state_dbg, bus.alucontrol, bus.zeroext);
        end
        tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd10 || bus.regwrite !== 1'b1) begin
            errors++; $display("FAIL ori_wb act_state=%0d act_rw=%b exp=10/1", bus.state_dbg, bus.regwrite);
        end
`else
        checks++;
        if (bus.state_dbg !== 4'd15 || bus.fault !== 1'b1 || bus.zeroext !== 2'b00) begin
            errors++; $display("FAIL ori_fault act_state=%0d act_fault=%b act_zx=%b exp=15/1/00", bus.state_dbg, bus.fault, bus.zeroext);
        end
`endif
    endtask

    task automatic test_timeout();
        int fetch_cycles;
        do_reset();
        bus.op = 6'b100011; bus.mem_ready = 1'b0;
        fetch_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.state_dbg == 4'd0 && bus.mem_req == 1'b1) fetch_cycles++;
            tick();
        end
        #1;
        checks++;
        if (fetch_cycles !== 16) begin errors++; $display("FAIL to_wait act=%0d exp=16", fetch_cycles); end
        checks++;
        if (bus.state_dbg !== 4'd15 || bus.fault !== 1'b1) begin
            errors++; $display("FAIL to_fault act_state=%0d act_fault=%b exp=15/1", bus.state_dbg, bus.fault);
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        checks++;
        if (bus.fault !== 1'b1 || bus.state_dbg !== 4'd15) begin
            errors++; $display("FAIL to_sticky act_state=%0d act_fault=%b exp=15/1", bus.state_dbg, bus.fault);
        end
        // MEM_TIMEOUT=0 instance: wait indefinitely
        do_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        #1;
        checks++;
        if (bus_nt.state_dbg !== 4'd0 || bus_nt.fault !== 1'b0 || bus_nt.mem_req !== 1'b1) begin
            errors++; $display("FAIL nt_hold act_state=%0d act_fault=%b exp=0/0", bus_nt.state_dbg, bus_nt.fault);
        end
        do_reset();
        #1;
        checks++;
        if (bus.fault !== 1'b0 || bus.state_dbg !== 4'd0) begin
            errors++; $display("FAIL to_clear act_state=%0d act_fault=%b exp=0/0", bus.state_dbg, bus.fault);
        end
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        bus.op = 6'b100011; bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0 || bus.irwrite !== 1'b1) begin
            errors++; $display("FAIL lim_fetch act_state=%0d act_ir=%b exp=0/1", bus.state_dbg, bus.irwrite);
        end
        tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd1 || bus.fault !== 1'b0) begin
            errors++; $display("FAIL lim_decode act_state=%0d act_fault=%b exp=1/0", bus.state_dbg, bus.fault);
        end
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        bus.op = 6'b101011; bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd5) begin errors++; $display("FAIL mw_enter act=%0d exp=5", bus.state_dbg); end
        bus.mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0 || bus.memwrite !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL mw_reset act_state=%0d act_mw=%b act_req=%b exp=0/0/0", bus.state_dbg, bus.memwrite, bus.mem_req);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0 || bus.mem_req !== 1'b1 || bus.irwrite !== 1'b1) begin
            errors++; $display("FAIL mw_resume act_state=%0d act_req=%b act_ir=%b exp=0/1/1", bus.state_dbg, bus.mem_req, bus.irwrite);
        end
        tick();
        #1;
        checks++;
        if (bus.state_dbg !== 4'd1) begin errors++; $display("FAIL mw_decode act=%0d exp=1", bus.state_dbg); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_beq();
        test_addi_jmp();
        test_illegal();
        test_ori();
        test_timeout();
        test_ready_at_limit();
        test_reset_midwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
